// File: rtl/carbon_arch_pkg.sv
// carbon_arch_pkg: debug CSR map, breakpoint kinds and breakpoint slot layout
package carbon_arch_pkg;
    localparam logic [31:0] CARBON_CSR_DBG_CTRL   = 32'h0000_07B0;
    localparam logic [31:0] CARBON_CSR_DBG_STEP   = 32'h0000_07B1;
    localparam logic [31:0] CARBON_CSR_DBG_STATUS = 32'h0000_07C0;
    localparam logic [31:0] DBG_OFF_HSEL     = 32'd1;
    localparam logic [31:0] DBG_OFF_HIT      = 32'd2;
    localparam logic [31:0] DBG_OFF_BP_INDEX = 32'd3;
    localparam logic [31:0] DBG_OFF_BP_ADDR  = 32'd4;
    localparam logic [31:0] DBG_OFF_BP_MASK  = 32'd5;
    localparam logic [31:0] DBG_OFF_BP_CTRL  = 32'd6;

    typedef enum logic [1:0] {
        BP_EXEC  = 2'd0,
        BP_LOAD  = 2'd1,
        BP_STORE = 2'd2,
        BP_ANY   = 2'd3
    } bp_kind_e;

    typedef struct packed {
        logic        enable;
        bp_kind_e    kind;
        logic        action;
        logic [31:0] addr;
        logic [31:0] mask;
    } bp_slot_t;
endpackage

// File: rtl/csr_if.sv
// csr_if: single-outstanding CSR request port with a held response
interface csr_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        rsp_side_effect;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_side_effect
    );
    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_side_effect
    );
endinterface

// File: rtl/dbg_bp_match.sv
// dbg_bp_match: one break/watch slot compared against every hart's PC or data address
module dbg_bp_match
    import carbon_arch_pkg::*;
#(
    parameter int NUM_HARTS = 4,
    parameter int ADDR_W    = 32
) (
    input  bp_slot_t                    i_slot,
    input  logic [NUM_HARTS-1:0]        i_pc_valid,
    input  logic [NUM_HARTS*ADDR_W-1:0] i_pc,
    input  logic [NUM_HARTS-1:0]        i_ma_valid,
    input  logic [NUM_HARTS-1:0]        i_ma_write,
    input  logic [NUM_HARTS*ADDR_W-1:0] i_ma_addr,
    output logic [NUM_HARTS-1:0]        o_hit
);
    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic              w_qual;
        logic [ADDR_W-1:0] w_addr;
        assign w_qual = i_slot.kind == BP_EXEC  ? i_pc_valid[h] :
                        i_slot.kind == BP_LOAD  ? i_ma_valid[h] & ~i_ma_write[h] :
                        i_slot.kind == BP_STORE ? i_ma_valid[h] & i_ma_write[h] : i_ma_valid[h];
        assign w_addr = i_slot.kind == BP_EXEC ? i_pc[h*ADDR_W +: ADDR_W] : i_ma_addr[h*ADDR_W +: ADDR_W];
        assign o_hit[h] = i_slot.enable & w_qual &
                          (((w_addr ^ i_slot.addr[ADDR_W-1:0]) & ~i_slot.mask[ADDR_W-1:0]) == '0);
    end
endmodule

// File: rtl/debug_ctrl_mh.sv
// debug_ctrl_mh: multi-hart halt/run/step control with local break/watch comparators
module debug_ctrl_mh
    import carbon_arch_pkg::*;
#(
    parameter int NUM_HARTS = 4,
    parameter int NUM_BP    = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    csr_if.slave                        csr,
    output logic [NUM_HARTS-1:0]        o_halt_req,
    output logic [NUM_HARTS-1:0]        o_run_req,
    output logic [NUM_HARTS-1:0]        o_step_req,
    input  logic [NUM_HARTS-1:0]        i_halt_ack,
    input  logic [NUM_HARTS-1:0]        i_pc_valid,
    input  logic [NUM_HARTS*ADDR_W-1:0] i_pc,
    input  logic [NUM_HARTS-1:0]        i_ma_valid,
    input  logic [NUM_HARTS-1:0]        i_ma_write,
    input  logic [NUM_HARTS*ADDR_W-1:0] i_ma_addr
);
    localparam logic [31:0] AMASK = 32'((33'h1 << ADDR_W) - 33'h1);
    localparam logic [31:0] B     = CARBON_CSR_DBG_STATUS;

    bp_slot_t             r_slot [NUM_BP];
    logic [NUM_HARTS-1:0] r_hsel;
    logic [NUM_BP-1:0]    r_hit;
    logic [3:0]           r_hit_hart;
    logic [3:0]           r_bp_idx;
    logic                 r_rsp_valid;
    logic                 r_rsp_fault;
    logic                 r_rsp_se;
    logic [31:0]          r_rsp_rdata;

    logic [NUM_HARTS-1:0] w_hit [NUM_BP];
    logic [NUM_BP-1:0]    w_slot_hit;
    logic [NUM_HARTS-1:0] w_hart_hit, w_bp_halt, w_halt_set, w_halt_clr, w_step;
    logic [NUM_BP-1:0]    w_w1c;
    logic [3:0]           w_low;
    logic                 w_acc, w_we, w_fault, w_bp_ok;
    logic [31:0]          w_rdata, w_addr, w_wdata;
    bp_slot_t             w_cur;

    for (genvar s = 0; s < NUM_BP; s++) begin : g_slot
        dbg_bp_match #(.NUM_HARTS(NUM_HARTS), .ADDR_W(ADDR_W)) u_match (
            .i_slot    (r_slot[s]),
            .i_pc_valid(i_pc_valid),
            .i_pc      (i_pc),
            .i_ma_valid(i_ma_valid),
            .i_ma_write(i_ma_write),
            .i_ma_addr (i_ma_addr),
            .o_hit     (w_hit[s])
        );
        assign w_slot_hit[s] = |w_hit[s];
    end

    always_comb begin
        w_hart_hit = '0;
        w_bp_halt  = '0;
        for (int s = 0; s < NUM_BP; s++) begin
            w_hart_hit |= w_hit[s];
            w_bp_halt  |= r_slot[s].action ? w_hit[s] : '0;
        end
        w_low = '0;
        for (int h = NUM_HARTS - 1; h >= 0; h--) if (w_hart_hit[h]) w_low = 4'(h);
    end

    assign w_addr          = csr.req_addr;
    assign w_wdata         = csr.req_wdata;
    assign csr.req_ready   = !r_rsp_valid;
    assign w_acc           = csr.req_valid & !r_rsp_valid;
    assign w_bp_ok         = {1'b0, r_bp_idx} < 5'(NUM_BP);

    always_comb begin
        w_cur = '0;
        for (int s = 0; s < NUM_BP; s++) if (r_bp_idx == 4'(s)) w_cur = r_slot[s];
        w_fault = 1'b0;
        w_rdata = '0;
        case (w_addr)
            CARBON_CSR_DBG_CTRL: begin
                w_fault = csr.req_write & (&w_wdata[1:0]);
                w_rdata[NUM_HARTS-1:0] = o_halt_req;
            end
            CARBON_CSR_DBG_STEP: w_fault = !csr.req_write;
            B: begin
                w_fault = csr.req_write;
                w_rdata[NUM_HARTS-1:0] = i_halt_ack;
            end
            B + DBG_OFF_HSEL:     w_rdata[NUM_HARTS-1:0] = r_hsel;
            B + DBG_OFF_HIT: begin
                w_rdata[NUM_BP-1:0] = r_hit;
                w_rdata[19:16]      = |r_hit ? r_hit_hart : 4'd0;
                w_rdata[31]         = |r_hit;
            end
            B + DBG_OFF_BP_INDEX: w_rdata[3:0] = r_bp_idx;
            B + DBG_OFF_BP_ADDR: begin
                w_fault = !w_bp_ok;
                w_rdata = w_cur.addr;
            end
            B + DBG_OFF_BP_MASK: begin
                w_fault = !w_bp_ok;
                w_rdata = w_cur.mask;
            end
            B + DBG_OFF_BP_CTRL: begin
                w_fault = !w_bp_ok;
                w_rdata[3:0] = {w_cur.action, w_cur.kind, w_cur.enable};
            end
            default: w_fault = 1'b1;
        endcase
    end

    assign w_we       = w_acc & csr.req_write & !w_fault;
    assign w_halt_set = (w_we && w_addr == CARBON_CSR_DBG_CTRL && w_wdata[0]) ? r_hsel : '0;
    assign w_halt_clr = (w_we && w_addr == CARBON_CSR_DBG_CTRL && w_wdata[1]) ? r_hsel : '0;
    assign w_step     = (w_we && w_addr == CARBON_CSR_DBG_STEP) ? r_hsel & i_halt_ack : '0;
    assign w_w1c      = (w_we && w_addr == B + DBG_OFF_HIT) ? w_wdata[NUM_BP-1:0] : '0;

    // Breakpoint halts override a same-cycle resume; new hits override W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_halt_req  <= '0;
            o_run_req   <= '0;
            o_step_req  <= '0;
            r_hsel      <= '0;
            r_hit       <= '0;
            r_hit_hart  <= '0;
            r_bp_idx    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_fault <= 1'b0;
            r_rsp_se    <= 1'b0;
            r_rsp_rdata <= '0;
            for (int s = 0; s < NUM_BP; s++) r_slot[s] <= '0;
        end else begin
            o_halt_req <= (o_halt_req | w_halt_set) & ~w_halt_clr | w_bp_halt;
            o_run_req  <= w_halt_clr & ~w_bp_halt;
            o_step_req <= w_step;
            r_hit      <= (r_hit & ~w_w1c) | w_slot_hit;
            if (|w_hart_hit) r_hit_hart <= w_low;
            if (w_we && w_addr == B + DBG_OFF_HSEL) r_hsel <= w_wdata[NUM_HARTS-1:0];
            if (w_we && w_addr == B + DBG_OFF_BP_INDEX) r_bp_idx <= w_wdata[3:0];
            for (int s = 0; s < NUM_BP; s++) begin
                if (w_we && r_bp_idx == 4'(s)) begin
                    if (w_addr == B + DBG_OFF_BP_ADDR) r_slot[s].addr <= w_wdata & AMASK;
                    if (w_addr == B + DBG_OFF_BP_MASK) r_slot[s].mask <= w_wdata & AMASK;
                    if (w_addr == B + DBG_OFF_BP_CTRL) begin
                        r_slot[s].enable <= w_wdata[0];
                        r_slot[s].kind   <= bp_kind_e'(w_wdata[2:1]);
                        r_slot[s].action <= w_wdata[3];
                    end
                end
            end
            if (w_acc) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_rdata;
                r_rsp_fault <= w_fault;
                r_rsp_se    <= csr.req_write & !w_fault;
            end else if (csr.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign csr.rsp_valid       = r_rsp_valid;
    assign csr.rsp_rdata       = r_rsp_rdata;
    assign csr.rsp_fault       = r_rsp_fault;
    assign csr.rsp_side_effect = r_rsp_se;
endmodule

// File: tb/tb_debug_ctrl_mh.sv
// tb_debug_ctrl_mh: directed and random checks of debug_ctrl_mh against a behavioural model
module tb_debug_ctrl_mh;
    import carbon_arch_pkg::*;

    localparam int NH = 4;
    localparam int NB = 4;
    localparam int AW = 32;
    localparam logic [31:0] B    = CARBON_CSR_DBG_STATUS;
    localparam logic [31:0] CTRL = CARBON_CSR_DBG_CTRL;
    localparam logic [31:0] STEP = CARBON_CSR_DBG_STEP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NH-1:0] halt_req, run_req, step_req;
    logic [NH-1:0] halt_ack = '0;
    logic [NH-1:0] pc_valid = '0;
    logic [NH-1:0] ma_valid = '0;
    logic [NH-1:0] ma_write = '0;
    logic [NH*AW-1:0] pc = '0;
    logic [NH*AW-1:0] ma_addr = '0;
    int n_cmp = 0;
    int n_bad = 0;

    csr_if u_csr();

    debug_ctrl_mh #(.NUM_HARTS(NH), .NUM_BP(NB), .ADDR_W(AW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .csr       (u_csr),
        .o_halt_req(halt_req),
        .o_run_req (run_req),
        .o_step_req(step_req),
        .i_halt_ack(halt_ack),
        .i_pc_valid(pc_valid),
        .i_pc      (pc),
        .i_ma_valid(ma_valid),
        .i_ma_write(ma_write),
        .i_ma_addr (ma_addr)
    );

    always #5 clk = ~clk;

    logic [NH-1:0] m_halt, m_hsel, m_run, m_step;
    logic [NB-1:0] m_hit;
    logic [3:0]    m_hart, m_idx;
    logic          m_en [NB];
    logic          m_act [NB];
    logic [1:0]    m_kind [NB];
    logic [31:0]   m_ba [NB];
    logic [31:0]   m_bm [NB];
    logic          m_rv, m_rf, m_rs, m_rck;
    logic [31:0]   m_rd;

    logic [31:0]   got_rd;
    logic          got_f, got_se;
    logic [NH-1:0] got_st, got_run;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_halt = '0; m_hsel = '0; m_run = '0; m_step = '0;
        m_hit = '0; m_hart = '0; m_idx = '0;
        m_rv = 0; m_rf = 0; m_rs = 0; m_rck = 0; m_rd = '0;
        for (int s = 0; s < NB; s++) begin
            m_en[s] = 0; m_act[s] = 0; m_kind[s] = 0; m_ba[s] = 0; m_bm[s] = 0;
        end
    endtask

    // One clock of the reference: compute what the next edge must produce from current inputs.
    task automatic model_step();
        logic [NB-1:0] hs;
        logic [NH-1:0] bh, n_halt;
        logic [NB-1:0] w1c;
        logic [31:0]   a, wd, rd;
        logic          acc, wr, f;
        int            low, i;
        hs = '0; bh = '0; w1c = '0; low = -1;
        for (int s = 0; s < NB; s++) begin
            for (int h = 0; h < NH; h++) begin
                logic q;
                logic [AW-1:0] ad;
                ad = ma_addr[h*AW +: AW];
                case (m_kind[s])
                    2'd0: begin q = pc_valid[h]; ad = pc[h*AW +: AW]; end
                    2'd1: q = ma_valid[h] && !ma_write[h];
                    2'd2: q = ma_valid[h] && ma_write[h];
                    default: q = ma_valid[h];
                endcase
                if (m_en[s] && q && (((ad ^ m_ba[s]) & ~m_bm[s]) == 0)) begin
                    hs[s] = 1;
                    if (m_act[s]) bh[h] = 1;
                    if (low < 0 || h < low) low = h;
                end
            end
        end
        a = u_csr.req_addr; wd = u_csr.req_wdata; wr = u_csr.req_write;
        acc = u_csr.req_valid && !m_rv;
        f = 0; rd = '0; n_halt = m_halt; m_run = '0; m_step = '0;
        i = int'(m_idx);
        if (acc) begin
            if (a == CTRL) begin
                if (!wr) rd = 32'(m_halt);
                else if (wd[1:0] == 2'b11) f = 1;
                else begin
                    if (wd[0]) n_halt |= m_hsel;
                    if (wd[1]) begin n_halt &= ~m_hsel; m_run = m_hsel; end
                end
            end else if (a == STEP) begin
                if (!wr) f = 1; else m_step = m_hsel & halt_ack;
            end else if (a == B) begin
                if (wr) f = 1; else rd = 32'(halt_ack);
            end else if (a == B + 1) begin
                if (wr) m_hsel = wd[NH-1:0]; else rd = 32'(m_hsel);
            end else if (a == B + 2) begin
                if (wr) w1c = wd[NB-1:0];
                else begin
                    rd = 32'(m_hit);
                    if (m_hit != 0) begin rd[19:16] = m_hart; rd[31] = 1; end
                end
            end else if (a == B + 3) begin
                if (wr) m_idx = wd[3:0]; else rd = 32'(m_idx);
            end else if (a >= B + 4 && a <= B + 6) begin
                if (i >= NB) f = 1;
                else if (a == B + 4) begin
                    if (wr) m_ba[i] = wd; else rd = m_ba[i];
                end else if (a == B + 5) begin
                    if (wr) m_bm[i] = wd; else rd = m_bm[i];
                end else begin
                    if (wr) begin m_en[i] = wd[0]; m_kind[i] = wd[2:1]; m_act[i] = wd[3]; end
                    else rd = {28'd0, m_act[i], m_kind[i], m_en[i]};
                end
            end else f = 1;
        end
        m_hit = (m_hit & ~w1c) | hs;
        if (low >= 0) m_hart = 4'(low);
        m_halt = n_halt | bh;
        m_run &= ~bh;
        if (acc) begin
            m_rv = 1; m_rf = f; m_rs = wr && !f; m_rck = !wr && !f; m_rd = rd;
        end else if (u_csr.rsp_ready) m_rv = 0;
    endtask

    task automatic check_all();
        chk("halt_req", 32'(halt_req), 32'(m_halt));
        chk("run_req", 32'(run_req), 32'(m_run));
        chk("step_req", 32'(step_req), 32'(m_step));
        chk("rsp_valid", 32'(u_csr.rsp_valid), 32'(m_rv));
        chk("req_ready", 32'(u_csr.req_ready), 32'(!m_rv));
        if (m_rv) begin
            chk("rsp_fault", 32'(u_csr.rsp_fault), 32'(m_rf));
            chk("rsp_side_effect", 32'(u_csr.rsp_side_effect), 32'(m_rs));
            if (m_rck) chk("rsp_rdata", u_csr.rsp_rdata, m_rd);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic csr_op(input logic [31:0] a, input logic w, input logic [31:0] d);
        int   n;
        logic rdy;
        n = 0;
        u_csr.req_valid = 1; u_csr.req_addr = a; u_csr.req_write = w; u_csr.req_wdata = d;
        u_csr.rsp_ready = 1;
        do begin
            rdy = u_csr.req_ready;
            cycle();
            n++;
        end while (!rdy && n < 20);
        if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
        u_csr.req_valid = 0;
        got_rd = u_csr.rsp_rdata; got_f = u_csr.rsp_fault; got_se = u_csr.rsp_side_effect;
        got_st = step_req; got_run = run_req;
        cycle();
    endtask

    localparam logic [31:0] RAND_ADDR [10] = '{CTRL, STEP, B, B + 1, B + 2, B + 3, B + 4, B + 5, B + 6, 32'h123};

    initial begin
        logic [31:0] a;
        u_csr.req_valid = 0; u_csr.req_addr = '0; u_csr.req_write = 0; u_csr.req_wdata = '0;
        u_csr.rsp_ready = 1;
        m_reset();
        #2;
        chk("rst_halt", 32'(halt_req), 0);
        chk("rst_run", 32'(run_req), 0);
        chk("rst_step", 32'(step_req), 0);
        chk("rst_rsp_valid", 32'(u_csr.rsp_valid), 0);
        chk("rst_req_ready", 32'(u_csr.req_ready), 1);
        #10 rst_n = 1;
        cycle();

        csr_op(B + 1, 1, 32'h5);
        csr_op(CTRL, 1, 32'h1);
        chk("halt_set", 32'(halt_req), 32'h5);
        csr_op(CTRL, 0, 0);
        chk("ctrl_read", got_rd, 32'h5);

        halt_ack = 4'h5;
        csr_op(CTRL, 1, 32'h2);
        chk("run_pulse", 32'(got_run), 32'h5);
        chk("halt_clear", 32'(halt_req), 0);
        csr_op(CTRL, 1, 32'h3);
        chk("ctrl3_fault", 32'(got_f), 1);
        chk("ctrl3_se", 32'(got_se), 0);

        halt_ack = '0;
        csr_op(B + 3, 1, 1);
        csr_op(B + 4, 1, 32'h1000);
        csr_op(B + 5, 1, 32'hF);
        csr_op(B + 6, 1, 32'h9);
        pc[2*AW +: AW] = 32'h100C; pc_valid = 4'b0100;
        cycle();
        pc_valid = '0;
        chk("exec_bp_halt", 32'(halt_req[2]), 1);
        csr_op(B + 2, 0, 0);
        chk("hit_read", got_rd, 32'h8002_0002);
        csr_op(B + 2, 1, 32'h2);
        csr_op(B + 2, 0, 0);
        chk("hit_w1c", got_rd, 0);

        csr_op(B + 3, 1, 0);
        csr_op(B + 4, 1, 32'h2000);
        csr_op(B + 5, 1, 0);
        csr_op(B + 6, 1, 32'hD);
        ma_addr[1*AW +: AW] = 32'h2000; ma_valid = 4'b0010; ma_write = 4'b0000;
        cycle();
        ma_valid = '0;
        chk("load_no_hit", 32'(halt_req[1]), 0);
        csr_op(B + 1, 1, 32'h2);
        ma_valid = 4'b0010; ma_write = 4'b0010;
        csr_op(CTRL, 1, 32'h2);
        ma_valid = '0; ma_write = '0;
        chk("halt_wins", 32'(halt_req[1]), 1);
        chk("no_run_on_halt", 32'(got_run), 0);

        csr_op(B + 3, 1, NB);
        csr_op(B + 6, 1, 32'h1);
        chk("bpidx_fault", 32'(got_f), 1);
        chk("bpidx_se", 32'(got_se), 0);
        csr_op(32'h0, 0, 0);
        chk("unmapped_fault", 32'(got_f), 1);

        u_csr.req_valid = 1; u_csr.req_addr = B + 1; u_csr.req_write = 0; u_csr.rsp_ready = 0;
        cycle();
        u_csr.req_valid = 0;
        repeat (3) begin
            cycle();
            chk("hold_req_ready", 32'(u_csr.req_ready), 0);
            chk("hold_rsp_valid", 32'(u_csr.rsp_valid), 1);
        end
        u_csr.rsp_ready = 1;
        cycle();

        csr_op(B + 1, 1, 32'h3);
        halt_ack = 4'h1;
        csr_op(STEP, 1, 0);
        chk("step_pulse", 32'(got_st), 32'h1);

        for (int c = 0; c < 3000; c++) begin
            a = RAND_ADDR[$urandom_range(0, 9)];
            u_csr.req_valid = 1'($urandom);
            u_csr.req_addr  = a;
            u_csr.req_write = 1'($urandom);
            u_csr.req_wdata = a == B + 3 ? 32'($urandom_range(0, 5)) :
                              a == B + 4 ? 32'h1000 + 32'($urandom_range(0, 1)) * 32'h1000 + 32'($urandom_range(0, 3)) :
                              a == B + 5 ? 32'($urandom_range(0, 1)) * 32'hF :
                              a == B + 6 ? 32'($urandom_range(0, 15)) : $urandom;
            u_csr.rsp_ready = $urandom_range(0, 3) != 0;
            halt_ack = 4'($urandom);
            pc_valid = 4'($urandom);
            ma_valid = 4'($urandom);
            ma_write = 4'($urandom);
            for (int h = 0; h < NH; h++) begin
                pc[h*AW +: AW]      = 32'h1000 + 32'($urandom_range(0, 31));
                ma_addr[h*AW +: AW] = 32'h1000 * 32'($urandom_range(1, 2)) + 32'($urandom_range(0, 7));
            end
            cycle();
        end
        u_csr.req_valid = 0; pc_valid = '0; ma_valid = '0;
        u_csr.rsp_ready = 1;
        cycle();

        u_csr.req_valid = 1; u_csr.req_addr = B + 1; u_csr.req_write = 0; u_csr.rsp_ready = 0;
        cycle();
        u_csr.req_valid = 0;
        #3 rst_n = 0;
        #1;
        chk("arst_halt", 32'(halt_req), 0);
        chk("arst_run", 32'(run_req), 0);
        chk("arst_step", 32'(step_req), 0);
        chk("arst_rsp_valid", 32'(u_csr.rsp_valid), 0);
        chk("arst_req_ready", 32'(u_csr.req_ready), 1);
        m_reset();
        @(posedge clk);
        #2 rst_n = 1;
        u_csr.rsp_ready = 1;
        cycle();
        chk("post_rst_rsp_valid", 32'(u_csr.rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/debug_ctrl_mh.md
Name: debug_ctrl_mh

Overview:
Multi-hart debug controller, successor to the single-hart hub control path. Drives per-hart halt/run/step over a single CSR slave port and holds NUM_BP local break/watch comparators, so harts need no breakpoint storage. A comparator hit can halt the offending hart autonomously, and the hit is recorded in sticky status. Trace and perf remain separate blocks alongside it.

Parameters:
NUM_HARTS, 4, number of controlled harts (1..16)
NUM_BP, 4, number of break/watch slots (1..16)
ADDR_W, 32, compared address width (8..32)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
csr  csr_if.slave  -  req_valid/req_ready/req_addr[31:0]/req_write/req_wdata[31:0]; rsp_valid/rsp_ready/rsp_rdata[31:0]/rsp_fault/rsp_side_effect
halt_req  out  NUM_HARTS  level halt request per hart
run_req  out  NUM_HARTS  1-cycle resume pulse per hart
step_req  out  NUM_HARTS  1-cycle single-step pulse per hart
halt_ack  in  NUM_HARTS  hart is halted
pc_valid  in  NUM_HARTS  instruction retire/fetch PC valid
pc  in  NUM_HARTS*ADDR_W  per-hart PC, hart h at [h*ADDR_W +: ADDR_W]
ma_valid  in  NUM_HARTS  memory access valid
ma_write  in  NUM_HARTS  1 = store
ma_addr  in  NUM_HARTS*ADDR_W  per-hart data address

Behaviour:
- Reset: all outputs 0; csr.req_ready=1; all registers 0 (HSEL=0, all slots disabled).
- CSR handshake: req_ready = !rsp_valid. Accepted request -> rsp_valid next cycle, held with data stable until rsp_ready. rsp_side_effect = write && !fault. Unmapped address -> fault, no state change.
- Map (B = CARBON_CSR_DBG_STATUS):
  - CARBON_CSR_DBG_CTRL: write bit0 = set halt_req for HSEL harts; bit1 = clear halt_req and pulse run_req for HSEL harts; bit0 and bit1 both set -> fault, no effect. Read: [NUM_HARTS-1:0] = halt_req.
  - CARBON_CSR_DBG_STEP: write pulses step_req for HSEL harts with halt_ack=1; other selected harts are ignored. Read -> fault.
  - B: read [NUM_HARTS-1:0] = halt_ack. Write -> fault.
  - B+1 HSEL: RW hart mask [NUM_HARTS-1:0]; upper bits read 0.
  - B+2 HIT: [NUM_BP-1:0] sticky per-slot hits, W1C. [19:16] = index of last hit hart. [31] = any hit.
  - B+3 BP_INDEX: RW [3:0].
  - B+4 BP_ADDR: RW [ADDR_W-1:0].
  - B+5 BP_MASK: RW [ADDR_W-1:0]; 1 = don't-care bit.
  - B+6 BP_CTRL: bit0 enable; [2:1] kind (0 exec, 1 load, 2 store, 3 any data); bit3 action (1 = halt hart, 0 = record only).
  - B+4..B+6 with BP_INDEX >= NUM_BP -> fault, no effect.
- Match for slot s, hart h: enabled AND qualifier AND ((addr ^ bp_addr) & ~bp_mask) == 0.
  - exec uses pc_valid/pc.
  - load: ma_valid & !ma_write. store: ma_valid & ma_write. any: ma_valid.
- Latency: a match in cycle N sets the HIT bit and, if action=1, sets halt_req[h] at N+1.
  - Several harts hit in one cycle: the lowest hart index is recorded; all slot bits are set; all matching harts with action=1 halt.
- Simultaneous events:
  - Breakpoint halt vs CSR resume on the same hart in the same cycle: halt wins; no run_req pulse for that hart.
  - HIT W1C vs new hit on the same bit: set wins.
  - Slot reprogrammed in the same cycle as a match: the old config applies.
- Pulses: run_req/step_req are high exactly one cycle. run_req and step_req are never both high for one hart in the same cycle.
- Reset mid-transaction: pending response is dropped; rsp_valid=0 the cycle after reset deassertion.

Decomposition:
- carbon_arch_pkg: B+1..B+6 offset constants, bp_kind_e enum, and bp_slot_t struct {enable, kind, action, addr, mask}.
- Sub-module dbg_bp_match: one slot vs all harts; outputs hit[NUM_HARTS]. Instantiated NUM_BP times via generate.

Test Plan:
- Write HSEL=0x5, then CTRL=0x1 -> halt_req=0x5 one cycle after the response; CTRL read returns 0x5.
- halt_ack=0x5, CTRL=0x2 -> halt_req=0x0; run_req=0x5 for exactly one cycle. CTRL=0x3 -> rsp_fault=1, no change.
- Slot 1: addr 0x1000, mask 0xF, exec, action=1, enable. Hart 2 pc=0x100C, pc_valid=1 -> next cycle halt_req[2]=1; HIT=0x8002_0002. Write HIT=0x2 -> HIT=0.
- Store watch on slot 0 at 0x2000: hart 1 load at 0x2000 -> no hit; hart 1 store -> hit. Same-cycle CSR resume of hart 1 -> halt_req[1] stays 1, no run pulse.
- BP_INDEX=NUM_BP, then write BP_CTRL -> fault, rsp_side_effect=0. Read of unmapped address -> fault. Hold rsp_ready=0 for 3 cycles -> rsp stable and req_ready=0 throughout.
- Step with HSEL=0x3, halt_ack=0x1 -> step_req=0x1 pulse only. Assert rst_n low mid-response -> all outputs 0 asynchronously.
